bnn_pin_driver: RTL and testbench
=================================

# bnn_pin_driver

Host-side initiator for the tiny BNN pin protocol. It turns a byte stream of parameters into the serial setup/param chain load, then runs inferences by presenting two input nibbles and capturing the 8-bit output. It lives on the controller side of the BNN's `clk_user` / `setup` / `param_in` / `x_bank_hi` / `x[3:0]` pins and generates the slow user clock itself.

## Interface
Parameters:
- `CHAIN_BITS`, default 256: total parameter-chain length in bits. Must be a multiple of 8 and ≥ 8.
- `DIV`, default 2: system-clock cycles per half-period of the generated `bnn_clk`. Must be ≥ 1.
- `SETTLE`, default 4: system-clock cycles between the final `bnn_clk` rising edge and sampling `bnn_y`.

Ports:
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_load` in 1: request a parameter load. Sampled only in IDLE.
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in 8: parameter byte stream, MSB first.
- `load_done` out 1: one-cycle pulse after the last chain bit is clocked.
- `infer_valid` in 1 / `infer_ready` out 1 / `infer_x` in 8: inference request.
- `result_valid` out 1: one-cycle pulse that qualifies `result`.
- `result` out 8: captured `bnn_y`. Holds its value until the next capture.
- `busy` out 1: high in any state other than IDLE.
- `bnn_clk`, `bnn_setup`, `bnn_param`, `bnn_bank_hi` out 1; `bnn_x` out 4: BNN pins.
- `bnn_y` in 8: BNN outputs.

## Operation
States: IDLE, LOAD, INF_LO, INF_HI, SETTLE_W.

- **IDLE**
  - `bnn_setup`=0, `bnn_clk`=0, `infer_ready`=1.
  - `start_load` goes to LOAD and has priority over `infer_valid` in the same cycle. While `start_load` is high, `infer_ready`=0.
- **LOAD**
  - `bnn_setup`=1 and `infer_ready`=0.
  - `s_ready`=1 only while the 8-bit shift register is empty. On each accepted byte, bits are sent MSB first.
  - Each bit is one `bnn_clk` pulse: `bnn_param` is set, then `bnn_clk` is low for DIV cycles, then high for DIV cycles.
  - If no byte is available, `bnn_clk` stays low. Stalls are unbounded.
  - After the CHAIN_BITS-th pulse finishes, the block pulses `load_done` and returns to IDLE. On that return, `bnn_setup` drops to 0 together with `bnn_clk` low.
- **Inference handshake:** `infer_valid & infer_ready` latches `infer_x`.
- **INF_LO:** `bnn_bank_hi`=0, `bnn_x`=`infer_x[3:0]`, one `bnn_clk` pulse.
- **INF_HI:** `bnn_bank_hi`=1, `bnn_x`=`infer_x[7:4]`, one `bnn_clk` pulse.
- **SETTLE_W:** wait SETTLE cycles, then set `result`←`bnn_y`, pulse `result_valid`, return to IDLE.
- Pin data (`bnn_param`, `bnn_setup`, `bnn_bank_hi`, `bnn_x`) changes only on the cycle `bnn_clk` falls or while it is already low. It is never changed in the same cycle as a rising edge.
- `bnn_param`, `bnn_bank_hi` and `bnn_x` read 0 in IDLE.
- A `start_load` or `infer_valid` that arrives while `busy` is ignored; it is not queued.

## Timing
- **Reset:** all outputs are 0 immediately (asynchronous), including `result`. State returns to IDLE.
- **Reset mid-LOAD:** the chain contents are undefined and the host must reload. No `load_done` is produced.
- **Load duration, no stalls:** `load_done` is asserted 2·DIV·CHAIN_BITS+1 cycles after the cycle `start_load` is accepted, provided the first byte is valid at that cycle.
- **Inference latency:** handshake at cycle 0, then `bnn_clk` rises at cycles DIV+1 and 3·DIV+1. `result_valid` is asserted at cycle 4·DIV+SETTLE+1. The next `infer_ready` is at cycle 4·DIV+SETTLE+2.
- **Bit counter:** width is clog2(CHAIN_BITS+1). It must not wrap; a terminal count of exactly CHAIN_BITS ends LOAD.
- **Byte boundary:** the next byte may be accepted in the same cycle that the final bit's high phase ends. This yields back-to-back pulses with no idle gap.

## Configuration
- `BNN_DRV_CHECKSUM_EN` defined:
  - Adds an output `load_sum` [7:0], the XOR of all bytes accepted during the most recent LOAD.
  - It is cleared when LOAD is entered and is valid when `load_done` pulses.
  - It resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- **Load with stall:** CHAIN_BITS=16, DIV=2, bytes 0xA5, 0x3C, with `s_valid` deasserted for 7 cycles between them.
  - Expect exactly 16 `bnn_clk` rises, with `bnn_param` sampled at the rises equal to 1010010100111100.
  - `bnn_setup`=1 throughout, single `load_done` pulse, no `bnn_clk` activity during the stall.
- **Inference:** `infer_x`=0x7E, BNN model returns y=0xC3 when its input is 0x7E.
  - First rise sees `bank_hi`=0, `x`=0xE; second rise sees `bank_hi`=1, `x`=0x7.
  - `result`=0xC3 and `result_valid` at cycle 4·DIV+SETTLE+1.
- **Priority and busy:**
  - `start_load` and `infer_valid` in the same IDLE cycle: LOAD is entered and the inference is not accepted.
  - `infer_valid` during LOAD: `infer_ready`=0 and it is dropped.
- **Reset mid-LOAD:** `rst_n` low after 5 bits.
  - Same-cycle outputs are all 0, state is IDLE, no `load_done`.
  - A subsequent full load succeeds.
- **Glitch-free pins:** over a randomized 200-transaction mix, assert that no pin data changes in the cycle `bnn_clk` rises.
- **Checksum (macro on):** load 0x12, 0x34, 0xFF, 0x00 (CHAIN_BITS=32); expect `load_sum`=0xD9 at `load_done`.

Source files
------------

// File: rtl/bnn_pin_driver_if.sv
// Host-side handshake bundle for bnn_pin_driver.
//   start_load              : request a parameter-chain load
//   s_valid/s_ready/s_data  : parameter byte stream, MSB first
//   load_done               : one-cycle pulse at the end of a load
//   infer_valid/ready/x     : inference request carrying two nibbles
//   result_valid/result     : captured BNN output and its qualifier
//   busy                    : driver is not idle
// master = host (controller firmware side), slave = bnn_pin_driver.
interface bnn_pin_driver_if;
    localparam int unsigned BYTE_W = 8;

    logic              start_load;
    logic              s_valid;
    logic              s_ready;
    logic [BYTE_W-1:0] s_data;
    logic              load_done;
    logic              infer_valid;
    logic              infer_ready;
    logic [BYTE_W-1:0] infer_x;
    logic              result_valid;
    logic [BYTE_W-1:0] result;
    logic              busy;

    modport master (
        output start_load, s_valid, s_data, infer_valid, infer_x,
        input  s_ready, load_done, infer_ready, result_valid, result, busy
    );

    modport slave (
        input  start_load, s_valid, s_data, infer_valid, infer_x,
        output s_ready, load_done, infer_ready, result_valid, result, busy
    );
endinterface

// File: rtl/bnn_pin_driver.sv
// Host-side initiator for the BNN pin protocol. Serialises a byte stream into
// the setup/param chain and runs inferences by presenting two nibbles on
// bnn_x and capturing bnn_y. Generates the slow bnn_clk from clk.
//
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset
//   host            : bnn_pin_driver_if.slave handshake bundle
//   bnn_clk         : generated user clock (DIV cycles low, DIV cycles high)
//   bnn_setup       : high while the parameter chain is being loaded
//   bnn_param       : chain data bit
//   bnn_bank_hi     : selects which nibble bnn_x carries
//   bnn_x[3:0]      : input nibble
//   bnn_y[7:0]      : BNN outputs
//   load_sum[7:0]   : XOR of bytes accepted in the last load
//                     (only with BNN_DRV_CHECKSUM_EN defined)
//
// Parameters: CHAIN_BITS (multiple of 8, >= 8), DIV (>= 1), SETTLE (>= 1).
// Pin data only moves while bnn_clk is low or on its falling cycle.
module bnn_pin_driver #(
    parameter int unsigned CHAIN_BITS = 256,
    parameter int unsigned DIV        = 2,
    parameter int unsigned SETTLE     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    bnn_pin_driver_if.slave  host,
    output logic             bnn_clk,
    output logic             bnn_setup,
    output logic             bnn_param,
    output logic             bnn_bank_hi,
    output logic [3:0]       bnn_x,
    input  logic [7:0]       bnn_y
`ifdef BNN_DRV_CHECKSUM_EN
    ,
    output logic [7:0]       load_sum
`endif
);

    localparam int unsigned BC_W = $clog2(CHAIN_BITS + 1);
    localparam int unsigned PH_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SR_W = 4;

    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(CHAIN_BITS - 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(DIV - 1);
    localparam logic [ST_W-1:0] ST_LAST  = ST_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        INF_LO   = 3'd2,
        INF_HI   = 3'd3,
        SETTLE_W = 3'd4
    } state_t;

    state_t          state;
    logic            armed;          // low only during the first cycle out of reset
    logic [BC_W-1:0] bit_cnt;        // chain bits fully clocked in this load
    logic [PH_W-1:0] ph_cnt;         // position inside the current bnn_clk half-period
    logic [ST_W-1:0] st_cnt;
    logic [6:0]      shreg;          // bits still to send after bnn_param
    logic [SR_W-1:0] sr_cnt;         // bits held in the byte register, 0 = empty
    logic [3:0]      x_hi_q;
    logic [7:0]      result_q;
    logic            result_valid_q;
    logic            load_done_q;

    logic idle_c;
    logic take_load_c;
    logic take_infer_c;
    logic ph_end_c;
    logic byte_last_c;
    logic chain_last_c;
    logic boundary_c;
    logic s_ready_c;
    logic accept_c;

    // Handshake decode; start_load wins over infer_valid in the same cycle.
    always_comb begin
        idle_c       = (state == IDLE) && armed;
        take_load_c  = idle_c && host.start_load;
        take_infer_c = idle_c && !host.start_load && host.infer_valid;
        ph_end_c     = (ph_cnt == PH_LAST);
        byte_last_c  = (sr_cnt == SR_W'(1));
        chain_last_c = (bit_cnt == LAST_BIT);
        // Last high cycle of a byte that is not the end of the chain: a new
        // byte taken here starts its low phase on the very next cycle.
        boundary_c   = (state == LOAD) && bnn_clk && ph_end_c && byte_last_c && !chain_last_c;
        s_ready_c    = take_load_c || ((state == LOAD) && (sr_cnt == '0)) || boundary_c;
        accept_c     = host.s_valid && s_ready_c;
    end

    assign host.s_ready      = s_ready_c;
    assign host.infer_ready  = idle_c && !host.start_load;
    assign host.busy         = (state != IDLE);
    assign host.load_done    = load_done_q;
    assign host.result_valid = result_valid_q;
    assign host.result       = result_q;

    // Main sequencer: state, clock generation and pin drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            armed          <= 1'b0;
            bit_cnt        <= '0;
            ph_cnt         <= '0;
            st_cnt         <= '0;
            shreg          <= '0;
            sr_cnt         <= '0;
            x_hi_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            load_done_q    <= 1'b0;
            bnn_clk        <= 1'b0;
            bnn_setup      <= 1'b0;
            bnn_param      <= 1'b0;
            bnn_bank_hi    <= 1'b0;
            bnn_x          <= '0;
        end else begin
            armed       <= 1'b1;
            load_done_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (take_load_c) begin
                        state     <= LOAD;
                        bnn_setup <= 1'b1;
                        bnn_clk   <= 1'b0;
                        bit_cnt   <= '0;
                        ph_cnt    <= '0;
                        if (host.s_valid) begin
                            bnn_param <= host.s_data[7];
                            shreg     <= host.s_data[6:0];
                            sr_cnt    <= SR_W'(8);
                        end else begin
                            sr_cnt    <= '0;
                        end
                    end else if (take_infer_c) begin
                        state       <= INF_LO;
                        x_hi_q      <= host.infer_x[7:4];
                        bnn_bank_hi <= 1'b0;
                        bnn_x       <= host.infer_x[3:0];
                        bnn_clk     <= 1'b0;
                        ph_cnt      <= '0;
                    end
                end

                LOAD: begin
                    if (sr_cnt == '0) begin
                        // Starved: bnn_clk parked low until a byte arrives.
                        if (accept_c) begin
                            bnn_param <= host.s_data[7];
                            shreg     <= host.s_data[6:0];
                            sr_cnt    <= SR_W'(8);
                            ph_cnt    <= '0;
                        end
                    end else if (!ph_end_c) begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end else begin
                        ph_cnt <= '0;
                        if (!bnn_clk) begin
                            bnn_clk <= 1'b1;
                        end else begin
                            bnn_clk <= 1'b0;
                            bit_cnt <= bit_cnt + BC_W'(1);
                            if (chain_last_c) begin
                                state       <= IDLE;
                                bnn_setup   <= 1'b0;
                                bnn_param   <= 1'b0;
                                sr_cnt      <= '0;
                                load_done_q <= 1'b1;
                            end else if (!byte_last_c) begin
                                bnn_param <= shreg[6];
                                shreg     <= {shreg[5:0], 1'b0};
                                sr_cnt    <= sr_cnt - SR_W'(1);
                            end else if (accept_c) begin
                                bnn_param <= host.s_data[7];
                                shreg     <= host.s_data[6:0];
                                sr_cnt    <= SR_W'(8);
                            end else begin
                                sr_cnt    <= '0;
                            end
                        end
                    end
                end

                INF_LO, INF_HI: begin
                    if (!ph_end_c) begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end else begin
                        ph_cnt <= '0;
                        if (!bnn_clk) begin
                            bnn_clk <= 1'b1;
                        end else begin
                            bnn_clk <= 1'b0;
                            if (state == INF_LO) begin
                                state       <= INF_HI;
                                bnn_bank_hi <= 1'b1;
                                bnn_x       <= x_hi_q;
                            end else begin
                                state  <= SETTLE_W;
                                st_cnt <= '0;
                            end
                        end
                    end
                end

                SETTLE_W: begin
                    // Capture after SETTLE cycles, hold one cycle for the pulse.
                    if (result_valid_q) begin
                        result_valid_q <= 1'b0;
                        state          <= IDLE;
                        bnn_bank_hi    <= 1'b0;
                        bnn_x          <= '0;
                    end else if (st_cnt == ST_LAST) begin
                        result_q       <= bnn_y;
                        result_valid_q <= 1'b1;
                    end else begin
                        st_cnt <= st_cnt + ST_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BNN_DRV_CHECKSUM_EN
    // Running XOR of accepted bytes, restarted on every load request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_sum <= '0;
        end else if (take_load_c) begin
            load_sum <= host.s_valid ? host.s_data : 8'h00;
        end else if (accept_c) begin
            load_sum <= load_sum ^ host.s_data;
        end
    end
`endif

endmodule

// File: tb/tb_bnn_pin_driver.sv
// Directed bench for bnn_pin_driver: inference vector table, stalled and
// back-to-back loads, priority/busy drop, reset mid-load, random mix.
module tb_bnn_pin_driver;
    localparam int unsigned CB   = 16;
    localparam int unsigned DIVP = 2;
    localparam int unsigned SETP = 4;
    localparam int LOAD_CYC = 2 * DIVP * CB + 1;   // 65
    localparam int INF_CYC  = 4 * DIVP + SETP + 1; // 13

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bnn_clk, bnn_setup, bnn_param, bnn_bank_hi;
    logic [3:0] bnn_x;
    logic [7:0] bnn_y;
`ifdef BNN_DRV_CHECKSUM_EN
    logic [7:0] load_sum;
`endif

    bnn_pin_driver_if host_if();

    always #5 clk = ~clk;

    bnn_pin_driver #(.CHAIN_BITS(CB), .DIV(DIVP), .SETTLE(SETP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (host_if),
        .bnn_clk     (bnn_clk),
        .bnn_setup   (bnn_setup),
        .bnn_param   (bnn_param),
        .bnn_bank_hi (bnn_bank_hi),
        .bnn_x       (bnn_x),
        .bnn_y       (bnn_y)
`ifdef BNN_DRV_CHECKSUM_EN
        ,
        .load_sum    (load_sum)
`endif
    );

    // BNN model: chain shift in setup, nibble latches otherwise; y = x ^ 0xBD.
    logic [CB-1:0] chain = '0;
    logic [3:0] m_lo = 4'h0;
    logic [3:0] m_hi = 4'h0;
    always @(posedge bnn_clk) begin
        if (bnn_setup) chain <= {chain[CB-2:0], bnn_param};
        else if (bnn_bank_hi) m_hi <= bnn_x;
        else m_lo <= bnn_x;
    end
    assign bnn_y = {m_hi, m_lo} ^ 8'hBD;

    int tests = 0;
    int fails = 0;

    // Pin monitor, sampled mid-cycle.
    int rise_cnt = 0, ld_cnt = 0, rv_cnt = 0, take_cnt = 0;
    int glitch_cnt = 0, idle_pin_err = 0, setup_err = 0, rdy_busy_err = 0;
    logic [15:0] load_bits = '0;
    logic [4:0] rise_rec [256];
    logic p_clk = 1'b0, p_setup = 1'b0, p_param = 1'b0, p_bank = 1'b0;
    logic [3:0] p_x = 4'h0;
    bit in_load = 1'b0;

    always @(negedge clk) begin
        if (bnn_clk && !p_clk) begin
            rise_cnt <= rise_cnt + 1;
            if (bnn_setup) load_bits <= {load_bits[14:0], bnn_param};
            rise_rec[rise_cnt[7:0]] <= {bnn_bank_hi, bnn_x};
            if (bnn_param != p_param || bnn_setup != p_setup ||
                bnn_bank_hi != p_bank || bnn_x != p_x)
                glitch_cnt <= glitch_cnt + 1;
        end
        if (host_if.load_done) ld_cnt <= ld_cnt + 1;
        if (host_if.result_valid) rv_cnt <= rv_cnt + 1;
        if (host_if.infer_valid && host_if.infer_ready) take_cnt <= take_cnt + 1;
        if (!host_if.busy && (bnn_param || bnn_bank_hi || bnn_x != 4'h0))
            idle_pin_err <= idle_pin_err + 1;
        if (in_load && !bnn_setup && !host_if.load_done) setup_err <= setup_err + 1;
        if (host_if.busy && host_if.infer_ready) rdy_busy_err <= rdy_busy_err + 1;
        p_clk   <= bnn_clk;
        p_setup <= bnn_setup;
        p_param <= bnn_param;
        p_bank  <= bnn_bank_hi;
        p_x     <= bnn_x;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Load two bytes; stall>0 holds s_valid low that many cycles after the
    // first byte drains; poke_inf raises infer_valid alongside start_load.
    task automatic do_load(input logic [7:0] b0, input logic [7:0] b1, input int stall,
                           input bit poke_inf, output int done_cyc);
        int empty_seen;
        int r0;
        bit got1;
        bit acc;
        done_cyc = -1; empty_seen = -1; got1 = 1'b0; r0 = 0;
        @(posedge clk); #1;
        host_if.start_load = 1'b1;
        host_if.s_valid    = 1'b1;
        host_if.s_data     = b0;
        if (poke_inf) begin
            host_if.infer_valid = 1'b1;
            host_if.infer_x     = 8'h55;
        end
        @(negedge clk);
        check("load_s_ready_c0", int'(host_if.s_ready), 1);
        check("load_infer_ready_c0", int'(host_if.infer_ready), 0);
        @(posedge clk); #1;
        in_load = 1'b1;
        host_if.start_load = 1'b0;
        if (stall == 0) host_if.s_data = b1;
        else host_if.s_valid = 1'b0;
        for (int c = 1; c < 400 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (host_if.load_done) begin
                done_cyc = c;
                in_load  = 1'b0;
            end
            acc = host_if.s_valid && host_if.s_ready;
            if (stall > 0 && !got1 && !host_if.s_valid && host_if.s_ready && empty_seen < 0) begin
                empty_seen = c;
                #1 r0 = rise_cnt;
            end
            if (empty_seen >= 0 && c == empty_seen + stall) begin
                #1 check("stall_no_bnn_clk", rise_cnt - r0, 0);
            end
            @(posedge clk); #1;
            if (acc) begin
                host_if.s_valid = 1'b0;
                got1 = 1'b1;
            end
            if (poke_inf) host_if.infer_valid = (c < 20);
            if (!got1 && stall > 0 && empty_seen >= 0 && c - empty_seen >= stall) begin
                host_if.s_valid = 1'b1;
                host_if.s_data  = b1;
            end
        end
        host_if.s_valid     = 1'b0;
        host_if.infer_valid = 1'b0;
        in_load = 1'b0;
    endtask

    task automatic do_infer(input logic [7:0] x, output logic [7:0] res, output int lat,
                            output logic [4:0] r_lo, output logic [4:0] r_hi,
                            output logic rdy0, output logic rdy_next);
        int rn;
        res = 8'h00; lat = -1;
        @(posedge clk); #1;
        host_if.infer_valid = 1'b1;
        host_if.infer_x     = x;
        @(negedge clk);
        rdy0 = host_if.infer_ready;
        #1 rn = rise_cnt;
        @(posedge clk); #1;
        host_if.infer_valid = 1'b0;
        for (int c = 1; c < 60 && lat < 0; c++) begin
            @(negedge clk);
            if (host_if.result_valid) begin
                lat = c;
                res = host_if.result;
            end
        end
        @(negedge clk);
        rdy_next = host_if.infer_ready;
        #1;
        r_lo = rise_rec[rn % 256];
        r_hi = rise_rec[(rn + 1) % 256];
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] lo;
        logic [3:0] hi;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] res;
        int lat, dc, r_before, ld_before, rv_before, tk_before, n_loads;
        logic [4:0] r_lo, r_hi;
        logic rdy0, rdy_next;

        vecs[0] = '{x: 8'h7E, y: 8'hC3, lo: 4'hE, hi: 4'h7};
        vecs[1] = '{x: 8'h00, y: 8'hBD, lo: 4'h0, hi: 4'h0};
        vecs[2] = '{x: 8'hFF, y: 8'h42, lo: 4'hF, hi: 4'hF};
        vecs[3] = '{x: 8'h5A, y: 8'hE7, lo: 4'hA, hi: 4'h5};
        vecs[4] = '{x: 8'h81, y: 8'h3C, lo: 4'h1, hi: 4'h8};
        vecs[5] = '{x: 8'h0F, y: 8'hB2, lo: 4'hF, hi: 4'h0};
        n_loads = 0;

        // Reset, with requests pending to exercise the ready gating.
        host_if.start_load  = 1'b1;
        host_if.s_valid     = 1'b1;
        host_if.s_data      = 8'hFF;
        host_if.infer_valid = 1'b1;
        host_if.infer_x     = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_pins", int'({bnn_clk, bnn_setup, bnn_param, bnn_bank_hi, bnn_x}), 0);
        check("rst_handshake", int'({host_if.s_ready, host_if.infer_ready, host_if.busy,
                                     host_if.load_done, host_if.result_valid}), 0);
        check("rst_result", int'(host_if.result), 0);
        host_if.start_load  = 1'b0;
        host_if.s_valid     = 1'b0;
        host_if.infer_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_infer_ready", int'(host_if.infer_ready), 1);

        // Inference vector table.
        for (int i = 0; i < 6; i++) begin
            do_infer(vecs[i].x, res, lat, r_lo, r_hi, rdy0, rdy_next);
            check($sformatf("inf%0d_ready_c0", i), int'(rdy0), 1);
            check($sformatf("inf%0d_result", i), int'(res), int'(vecs[i].y));
            check($sformatf("inf%0d_latency", i), lat, INF_CYC);
            check($sformatf("inf%0d_rise1", i), int'(r_lo), int'({1'b0, vecs[i].lo}));
            check($sformatf("inf%0d_rise2", i), int'(r_hi), int'({1'b1, vecs[i].hi}));
            check($sformatf("inf%0d_ready_next", i), int'(rdy_next), 1);
        end

        // Load with a 7-cycle stall between bytes.
        r_before = rise_cnt; ld_before = ld_cnt;
        do_load(8'hA5, 8'h3C, 7, 1'b0, dc);
        n_loads++;
        #1;
        check("stall_done_cycle", dc, LOAD_CYC + 8);
        check("stall_bits", int'(load_bits), 16'hA53C);
        check("stall_rises", rise_cnt - r_before, 16);
        check("stall_chain", int'(chain), 16'hA53C);
        repeat (2) @(negedge clk);
        check("stall_one_done", ld_cnt - ld_before, 1);
`ifdef BNN_DRV_CHECKSUM_EN
        check("stall_load_sum", int'(load_sum), 8'h99);
`endif

        // Back-to-back load; start_load and infer_valid collide, then
        // infer_valid stays up during LOAD and must be dropped.
        tk_before = take_cnt; rv_before = rv_cnt;
        do_load(8'h12, 8'h34, 0, 1'b1, dc);
        n_loads++;
        #1;
        check("b2b_done_cycle", dc, LOAD_CYC);
        check("b2b_bits", int'(load_bits), 16'h1234);
        repeat (20) @(negedge clk);
        check("prio_no_take", take_cnt - tk_before, 0);
        check("prio_no_result", rv_cnt - rv_before, 0);
`ifdef BNN_DRV_CHECKSUM_EN
        check("b2b_load_sum", int'(load_sum), 8'h26);
`endif

        // Reset after 5 bits of a load.
        ld_before = ld_cnt;
        r_before = rise_cnt;
        @(posedge clk); #1;
        host_if.start_load = 1'b1;
        host_if.s_valid    = 1'b1;
        host_if.s_data     = 8'hF0;
        @(posedge clk); #1;
        host_if.start_load = 1'b0;
        host_if.s_data     = 8'h0F;
        for (int c = 0; c < 100 && rise_cnt - r_before < 5; c++) begin
            @(negedge clk); #1;
        end
        check("mid_rises_reached", rise_cnt - r_before, 5);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pins", int'({bnn_clk, bnn_setup, bnn_param, bnn_bank_hi, bnn_x}), 0);
        check("mid_rst_handshake", int'({host_if.s_ready, host_if.infer_ready, host_if.busy,
                                         host_if.load_done, host_if.result_valid}), 0);
        check("mid_rst_result", int'(host_if.result), 0);
        repeat (2) @(negedge clk);
        host_if.s_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("mid_no_done", ld_cnt - ld_before, 0);
        do_load(8'hC3, 8'h5A, 0, 1'b0, dc);
        n_loads++;
        #1;
        check("reload_done_cycle", dc, LOAD_CYC);
        check("reload_chain", int'(chain), 16'hC35A);

        // Random mix of loads and inferences.
        for (int i = 0; i < 200; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                do_load(a, b, int'($urandom_range(0, 3)), 1'b0, dc);
                n_loads++;
                #1;
                check($sformatf("rnd%0d_load_bits", i), int'(load_bits), int'({a, b}));
            end else begin
                do_infer(a, res, lat, r_lo, r_hi, rdy0, rdy_next);
                check($sformatf("rnd%0d_result", i), int'(res), int'(a ^ 8'hBD));
            end
        end

        repeat (4) @(negedge clk);
        #1;
        check("glitch_free", glitch_cnt, 0);
        check("idle_pins_zero", idle_pin_err, 0);
        check("setup_held", setup_err, 0);
        check("ready_while_busy", rdy_busy_err, 0);
        check("load_done_count", ld_cnt, n_loads);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
